// File: rtl/ball_physics_pkg.sv
// Shared definitions for the pong ball engine: FSM states, default geometry,
// and small arithmetic helpers.
package ball_physics_pkg;

   typedef enum logic [1:0] {
      SERVE_WAIT = 2'd0,
      PLAY       = 2'd1,
      MISS       = 2'd2
   } ball_state_t;

   localparam int DEF_POSITION_REG_MAX   = 11;
   localparam int DEF_GRAPHICS_WIDTH     = 1280;
   localparam int DEF_GRAPHICS_HEIGHT    = 800;
   localparam int DEF_BORDER_WIDTH       = 50;
   localparam int DEF_BALL_RADIUS        = 10;
   localparam int DEF_BALL_START_X       = 640;
   localparam int DEF_BALL_START_Y       = 400;
   localparam int DEF_BALL_SPEED_X       = 4;
   localparam int DEF_BALL_SPEED_Y       = 3;
   localparam int DEF_PADDLE_WIDTH       = 20;
   localparam int DEF_PADDLE_LENGTH      = 200;
   localparam int DEF_SERVE_DELAY_FRAMES = 60;

   // Rally hit counter increment that sticks at full scale.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/ball_physics_vsync_tick.sv
// Frame tick generator: one-cycle pulse on each rising edge of vertical sync.
module vsync_tick (
   input  logic pixel_clock,
   input  logic reset,
   input  logic vga_vertical_sync,
   output logic tick
);

   logic last_vsync;

   // Remember last vsync level; reset to high so a vsync already high at
   // reset release is not mistaken for a new frame.
   always_ff @(posedge pixel_clock or posedge reset) begin
      if (reset) last_vsync <= 1'b1;
      else       last_vsync <= vga_vertical_sync;
   end

   assign tick = vga_vertical_sync & ~last_vsync;

endmodule

// File: rtl/ball_physics.sv
// Per-frame ball motion engine: serve delay, wall/paddle bounces, miss
// detection and rally hit counting, advanced once per vsync rising edge.
module ball_physics
   import ball_physics_pkg::*;
#(
   parameter int POSITION_REG_MAX   = DEF_POSITION_REG_MAX,
   parameter int GRAPHICS_WIDTH     = DEF_GRAPHICS_WIDTH,
   parameter int GRAPHICS_HEIGHT    = DEF_GRAPHICS_HEIGHT,
   parameter int BORDER_WIDTH       = DEF_BORDER_WIDTH,
   parameter int BALL_RADIUS        = DEF_BALL_RADIUS,
   parameter int BALL_START_X       = DEF_BALL_START_X,
   parameter int BALL_START_Y       = DEF_BALL_START_Y,
   parameter int BALL_SPEED_X       = DEF_BALL_SPEED_X,
   parameter int BALL_SPEED_Y       = DEF_BALL_SPEED_Y,
   parameter int PADDLE_WIDTH       = DEF_PADDLE_WIDTH,
   parameter int PADDLE_LENGTH      = DEF_PADDLE_LENGTH,
   parameter int SERVE_DELAY_FRAMES = DEF_SERVE_DELAY_FRAMES
) (
   input  logic                      pixel_clock,
   input  logic                      reset,
   input  logic                      vga_vertical_sync,
   input  logic [POSITION_REG_MAX:0] paddle_x,
   input  logic [POSITION_REG_MAX:0] paddle_y,
   output logic [POSITION_REG_MAX:0] ball_x,
   output logic [POSITION_REG_MAX:0] ball_y,
   output logic                      in_play,
   output logic                      hit_pulse,
   output logic                      miss_pulse,
   output logic [7:0]                hit_count
);

   localparam int P     = POSITION_REG_MAX + 1;
   // Two extra bits: signed, plus headroom for paddle_x+PADDLE_WIDTH at full scale.
   localparam int CW    = POSITION_REG_MAX + 3;
   localparam int CNT_W = (SERVE_DELAY_FRAMES > 1) ? $clog2(SERVE_DELAY_FRAMES) : 1;

   localparam int XMIN = BORDER_WIDTH + BALL_RADIUS;
   localparam int XMAX = GRAPHICS_WIDTH - BORDER_WIDTH - BALL_RADIUS;
   localparam int YMIN = BORDER_WIDTH + BALL_RADIUS;
   localparam int YMAX = GRAPHICS_HEIGHT - BORDER_WIDTH - BALL_RADIUS;

   typedef logic signed [CW-1:0] coord_t;
   typedef logic [P-1:0]         pos_t;

   localparam coord_t XMIN_C = coord_t'(XMIN);
   localparam coord_t XMAX_C = coord_t'(XMAX);
   localparam coord_t YMIN_C = coord_t'(YMIN);
   localparam coord_t YMAX_C = coord_t'(YMAX);
   localparam coord_t R_C    = coord_t'(BALL_RADIUS);
   localparam coord_t SPX_C  = coord_t'(BALL_SPEED_X);
   localparam coord_t SPY_C  = coord_t'(BALL_SPEED_Y);
   localparam coord_t PW_C   = coord_t'(PADDLE_WIDTH);
   localparam coord_t PL_C   = coord_t'(PADDLE_LENGTH);
   localparam pos_t   START_X = pos_t'(BALL_START_X);
   localparam pos_t   START_Y = pos_t'(BALL_START_Y);
   localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY_FRAMES - 1);

   ball_state_t      state;
   logic [CNT_W-1:0] serve_count;
   logic             dx_neg;
   logic             dy_neg;
   logic             tick;

   coord_t cur_x, cur_y, nx, ny, pad_x, pad_y, face;
   pos_t   x_next, y_next;
   logic   dx_neg_next, dy_neg_next;
   logic   paddle_hit, wall_miss;

   vsync_tick u_vsync_tick (
      .pixel_clock       (pixel_clock),
      .reset             (reset),
      .vga_vertical_sync (vga_vertical_sync),
      .tick              (tick)
   );

   // Candidate motion for the next PLAY tick; both axes resolve independently.
   always_comb begin
      cur_x = coord_t'(ball_x);
      cur_y = coord_t'(ball_y);
      pad_x = coord_t'(paddle_x);
      pad_y = coord_t'(paddle_y);
      nx    = cur_x + (dx_neg ? -SPX_C : SPX_C);
      ny    = cur_y + (dy_neg ? -SPY_C : SPY_C);
      face  = pad_x + PW_C;

      paddle_hit = dx_neg && (cur_x - R_C > face) && (nx - R_C <= face) &&
                   (pad_y <= cur_y) && (cur_y <= pad_y + PL_C);
      wall_miss  = !paddle_hit && (nx <= XMIN_C);

      y_next      = pos_t'(ny);
      dy_neg_next = dy_neg;
      if (ny <= YMIN_C) begin
         y_next      = pos_t'(YMIN_C);
         dy_neg_next = 1'b0;
      end else if (ny >= YMAX_C) begin
         y_next      = pos_t'(YMAX_C);
         dy_neg_next = 1'b1;
      end

      x_next      = pos_t'(nx);
      dx_neg_next = dx_neg;
      if (paddle_hit) begin
         x_next      = pos_t'(face + R_C);
         dx_neg_next = 1'b0;
      end else if (wall_miss) begin
         x_next      = ball_x;
      end else if (nx >= XMAX_C) begin
         x_next      = pos_t'(XMAX_C);
         dx_neg_next = 1'b1;
      end
   end

   // Serve / play / miss sequencing with registered ball state and pulses.
   always_ff @(posedge pixel_clock or posedge reset) begin
      if (reset) begin
         state       <= SERVE_WAIT;
         serve_count <= '0;
         ball_x      <= START_X;
         ball_y      <= START_Y;
         dx_neg      <= 1'b1;
         dy_neg      <= 1'b0;
         in_play     <= 1'b0;
         hit_pulse   <= 1'b0;
         miss_pulse  <= 1'b0;
         hit_count   <= '0;
      end else begin
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         case (state)
            SERVE_WAIT: begin
               if (tick) begin
                  if (serve_count == SERVE_LAST) begin
                     state       <= PLAY;
                     serve_count <= '0;
                     in_play     <= 1'b1;
                  end else begin
                     serve_count <= serve_count + 1'b1;
                  end
               end
            end
            PLAY: begin
               if (tick) begin
                  ball_y <= y_next;
                  dy_neg <= dy_neg_next;
                  ball_x <= x_next;
                  dx_neg <= dx_neg_next;
                  if (paddle_hit) begin
                     hit_pulse <= 1'b1;
                     hit_count <= sat_inc8(hit_count);
                  end else if (wall_miss) begin
                     state   <= MISS;
                     in_play <= 1'b0;
                  end
               end
            end
            MISS: begin
               miss_pulse <= 1'b1;
               hit_count  <= '0;
               ball_x     <= START_X;
               ball_y     <= START_Y;
               dx_neg     <= 1'b1;
               state      <= SERVE_WAIT;
            end
            default: state <= SERVE_WAIT;
         endcase
      end
   end

endmodule
